// File: rtl/output_channel_credit_scheduler.sv
// Credit-based enqueue scheduler for a set of output channels: one credit counter per channel, a one-cycle registered enqueue pulse per accept.
// Optional stall-cycle counter enabled by defining TIA_ENQUEUE_STALL_COUNTER_EN.
`ifndef TIA_NUM_OUTPUT_CHANNELS
`define TIA_NUM_OUTPUT_CHANNELS 4
`endif
`ifndef TIA_OCT_WIDTH
`define TIA_OCT_WIDTH 2
`endif

// Handshake: a request is taken in any cycle where req_valid && req_ready; req_ready is combinational from
// current credits only and the requester must hold req_oci/req_oct stable while valid and not ready.
module output_channel_credit_scheduler #(
  parameter int NUM_CHANNELS  = `TIA_NUM_OUTPUT_CHANNELS,
  parameter int TAG_WIDTH     = `TIA_OCT_WIDTH,
  parameter int CHANNEL_DEPTH = 4,
  localparam int CREDIT_WIDTH = $clog2(CHANNEL_DEPTH + 1)
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 req_valid,
  input  logic [NUM_CHANNELS-1:0]              req_oci,
  input  logic [TAG_WIDTH-1:0]                 req_oct,
  output logic                                 req_ready,
  input  logic [NUM_CHANNELS-1:0]              dequeue_signals,
  output logic [NUM_CHANNELS-1:0]              enqueue_signals,
  output logic [NUM_CHANNELS-1:0][TAG_WIDTH-1:0] output_channel_tags,
  output logic [NUM_CHANNELS-1:0]              credits_available,
  output logic                                 stalled,
  output logic                                 credit_overflow
`ifdef TIA_ENQUEUE_STALL_COUNTER_EN
  ,
  output logic [31:0]                          stall_cycles
`endif
);

  localparam logic [CREDIT_WIDTH-1:0] DEPTH_C = CREDIT_WIDTH'(CHANNEL_DEPTH);
  localparam logic [CREDIT_WIDTH-1:0] ONE_C   = CREDIT_WIDTH'(1);

  typedef enum logic {ST_RUN = 1'b0, ST_STALL = 1'b1} state_e;

  state_e                               state_q, state_d;
  logic [CREDIT_WIDTH-1:0]              credit_q [NUM_CHANNELS];
  logic [CREDIT_WIDTH-1:0]              credit_d [NUM_CHANNELS];
  logic                                 overflow_q, overflow_d;
  logic [NUM_CHANNELS-1:0]              enq_q, enq_d;
  logic [NUM_CHANNELS-1:0][TAG_WIDTH-1:0] tags_q, tags_d;
  logic                                 accept;
  logic [NUM_CHANNELS-1:0]              take_vec;

  always_comb begin
    req_ready = !reset;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (req_oci[i] && (credit_q[i] == '0)) req_ready = 1'b0;
    end
  end

  assign accept   = req_valid && req_ready;
  assign take_vec = {NUM_CHANNELS{accept}} & req_oci;

  always_comb begin
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      credits_available[i] = (credit_q[i] != '0);
    end
  end

  // A return at full credit with no take in the same cycle is dropped and flagged.
  always_comb begin
    overflow_d = overflow_q;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      credit_d[i] = credit_q[i];
      if (take_vec[i] && !dequeue_signals[i]) begin
        credit_d[i] = credit_q[i] - ONE_C;
      end else if (!take_vec[i] && dequeue_signals[i]) begin
        if (credit_q[i] == DEPTH_C) overflow_d = 1'b1;
        else                        credit_d[i] = credit_q[i] + ONE_C;
      end
    end
  end

  always_comb begin
    enq_d = accept ? req_oci : '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      tags_d[i] = take_vec[i] ? req_oct : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_RUN;
      overflow_q <= 1'b0;
      enq_q      <= '0;
      tags_q     <= '0;
      for (int i = 0; i < NUM_CHANNELS; i++) credit_q[i] <= DEPTH_C;
    end else begin
      state_q    <= state_d;
      overflow_q <= overflow_d;
      enq_q      <= enq_d;
      tags_q     <= tags_d;
      for (int i = 0; i < NUM_CHANNELS; i++) credit_q[i] <= credit_d[i];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (req_valid && !req_ready) state_d = ST_STALL;
      ST_STALL: if (accept || !req_valid)    state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  // Pulse outputs are masked while reset is high so a reset right after an accept drops that pulse.
  always_comb begin
    stalled             = (state_q == ST_STALL);
    credit_overflow     = overflow_q;
    enqueue_signals     = reset ? '0 : enq_q;
    output_channel_tags = reset ? '0 : tags_q;
  end

`ifdef TIA_ENQUEUE_STALL_COUNTER_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (req_valid && !req_ready && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_output_channel_credit_scheduler.sv
// Bench for output_channel_credit_scheduler: directed scenarios plus random traffic against an arithmetic credit model.
module tb_output_channel_credit_scheduler;

  localparam int NC    = 4;
  localparam int TW    = 2;
  localparam int DEPTH = 2;
  localparam int EW    = NC + NC * TW;

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic                   req_valid = 1'b0;
  logic [NC-1:0]          req_oci = '0;
  logic [TW-1:0]          req_oct = '0;
  logic                   req_ready;
  logic [NC-1:0]          dequeue_signals = '0;
  logic [NC-1:0]          enqueue_signals;
  logic [NC-1:0][TW-1:0]  output_channel_tags;
  logic [NC-1:0]          credits_available;
  logic                   stalled;
  logic                   credit_overflow;
`ifdef TIA_ENQUEUE_STALL_COUNTER_EN
  logic [31:0]            stall_cycles;
`endif

  output_channel_credit_scheduler #(
    .NUM_CHANNELS(NC), .TAG_WIDTH(TW), .CHANNEL_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_oci(req_oci), .req_oct(req_oct),
    .req_ready(req_ready), .dequeue_signals(dequeue_signals), .enqueue_signals(enqueue_signals),
    .output_channel_tags(output_channel_tags), .credits_available(credits_available),
    .stalled(stalled), .credit_overflow(credit_overflow)
`ifdef TIA_ENQUEUE_STALL_COUNTER_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  int          m_cred [NC];
  bit          m_ovf;
  bit          m_stalled;
  longint      m_stall_cnt;
  bit          last_blocked;
  logic [EW-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit model_ready(input bit rst, input logic [NC-1:0] oci);
    if (rst) return 1'b0;
    for (int i = 0; i < NC; i++) if (oci[i] && m_cred[i] == 0) return 1'b0;
    return 1'b1;
  endfunction

  // One clock: drive at negedge, check ready, advance model, check registered outputs after posedge.
  task automatic cycle(input bit rst, input bit valid, input logic [NC-1:0] oci,
                       input logic [TW-1:0] oct, input logic [NC-1:0] deq);
    bit              rdy;
    bit              acc;
    logic [NC*TW-1:0] etags;
    logic [EW-1:0]   e;
    logic [NC-1:0]   eav;
    @(negedge clk);
    reset = rst; req_valid = valid; req_oci = oci; req_oct = oct; dequeue_signals = deq;
    #1;
    rdy = model_ready(rst, oci);
    check_eq("req_ready", req_ready, rdy);
    acc = valid && rdy;
    if (acc) begin
      etags = '0;
      for (int i = 0; i < NC; i++) if (oci[i]) etags[i*TW +: TW] = oct;
      exp_q.push_back({oci, etags});
    end
    if (rst) begin
      for (int i = 0; i < NC; i++) m_cred[i] = DEPTH;
      m_ovf = 0; m_stalled = 0; m_stall_cnt = 0;
    end else begin
      for (int i = 0; i < NC; i++) begin
        int c;
        c = m_cred[i] - ((acc && oci[i]) ? 1 : 0) + (deq[i] ? 1 : 0);
        if (c > DEPTH) begin c = DEPTH; m_ovf = 1; end
        m_cred[i] = c;
      end
      m_stalled = valid && !rdy;
      if (valid && !rdy && m_stall_cnt < 64'hFFFF_FFFF) m_stall_cnt++;
    end
    last_blocked = !rst && valid && !rdy;
    @(posedge clk);
    #1;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    for (int i = 0; i < NC; i++) eav[i] = (m_cred[i] > 0);
    check_eq("enqueue_signals", enqueue_signals, e[EW-1 -: NC]);
    check_eq("output_channel_tags", output_channel_tags, e[NC*TW-1:0]);
    check_eq("credits_available", credits_available, eav);
    check_eq("stalled", stalled, m_stalled);
    check_eq("credit_overflow", credit_overflow, m_ovf);
`ifdef TIA_ENQUEUE_STALL_COUNTER_EN
    check_eq("stall_cycles", stall_cycles, m_stall_cnt);
`endif
  endtask

  initial begin
    logic [NC-1:0] r_oci;
    logic [TW-1:0] r_oct;
    bit            r_valid;

    cycle(1, 0, '0, '0, '0);
    cycle(1, 0, '0, '0, '0);
    check_eq("reset_avail", credits_available, 4'b1111);
    check_eq("reset_enq", enqueue_signals, 4'b0000);

    // multi-channel accept with tag
    cycle(0, 1, 4'b0101, 2'b10, '0);
    check_eq("r023_enq", enqueue_signals, 4'b0101);
    check_eq("r023_tags", output_channel_tags, 8'b00_10_00_10);
    cycle(0, 0, '0, '0, '0);
    check_eq("r023_pulse_gone", enqueue_signals, 4'b0000);

    // drain channel 0 then stall, credit return restores ready
    cycle(1, 0, '0, '0, '0);
    cycle(0, 1, 4'b0001, 2'b01, '0);
    cycle(0, 1, 4'b0001, 2'b01, '0);
    cycle(0, 1, 4'b0001, 2'b01, '0);
    check_eq("r024_stalled", stalled, 1'b1);
    check_eq("r024_ready_lo", req_ready, 1'b0);
    cycle(0, 1, 4'b0001, 2'b01, 4'b0001);
    check_eq("r024_ready_restored", req_ready, 1'b1);
    cycle(0, 1, 4'b0001, 2'b01, '0);
    cycle(0, 0, '0, '0, '0);

    // simultaneous take and return keeps credit
    cycle(1, 0, '0, '0, '0);
    cycle(0, 1, 4'b0001, 2'b11, '0);
    cycle(0, 1, 4'b0001, 2'b11, 4'b0001);
    check_eq("r025_avail", credits_available[0], 1'b1);
    cycle(0, 1, 4'b0001, 2'b11, '0);
    check_eq("r025_now_empty", req_ready, 1'b0);
    cycle(0, 0, '0, '0, '0);

    // return at full credit
    cycle(1, 0, '0, '0, '0);
    cycle(0, 0, '0, '0, 4'b1000);
    check_eq("r026_ovf", credit_overflow, 1'b1);
    cycle(0, 0, '0, '0, '0);
    cycle(0, 0, '0, '0, '0);
    check_eq("r026_ovf_sticky", credit_overflow, 1'b1);
    cycle(1, 0, '0, '0, '0);
    check_eq("r026_ovf_cleared", credit_overflow, 1'b0);

    // empty mask is accepted without a pulse
    cycle(0, 1, 4'b0000, 2'b11, '0);
    check_eq("r013_enq", enqueue_signals, 4'b0000);

`ifdef TIA_ENQUEUE_STALL_COUNTER_EN
    cycle(1, 0, '0, '0, '0);
    cycle(0, 1, 4'b0001, 2'b01, '0);
    cycle(0, 1, 4'b0001, 2'b01, '0);
    for (int k = 0; k < 5; k++) cycle(0, 1, 4'b0001, 2'b01, '0);
    check_eq("r027_stall_cycles", stall_cycles, 32'd5);
    cycle(0, 0, '0, '0, '0);
`endif

    // reset right after an accept suppresses the pulse
    cycle(1, 0, '0, '0, '0);
    @(negedge clk);
    reset = 0; req_valid = 1; req_oci = 4'b0010; req_oct = 2'b11; dequeue_signals = '0;
    @(posedge clk);
    #1 reset = 1;
    #1;
    check_eq("r019_enq_suppressed", enqueue_signals, 4'b0000);
    check_eq("r019_tags_suppressed", output_channel_tags, 8'b0);
    cycle(1, 0, '0, '0, '0);

    // random traffic, honouring hold-while-blocked
    r_oci = '0; r_oct = '0;
    for (int n = 0; n < 3000; n++) begin
      bit       r_rst;
      logic [NC-1:0] r_deq;
      r_rst = ($urandom_range(0, 79) == 0);
      if (!last_blocked) begin
        r_oci = NC'($urandom_range(0, (1 << NC) - 1));
        r_oct = TW'($urandom_range(0, (1 << TW) - 1));
      end
      r_valid = last_blocked ? ($urandom_range(0, 5) != 0) : ($urandom_range(0, 2) != 0);
      for (int i = 0; i < NC; i++) r_deq[i] = ($urandom_range(0, 3) == 0);
      cycle(r_rst, r_valid, r_oci, r_oct, r_deq);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
